// File: rtl/io_port_controller_if.sv
// rtl/io_port_controller_if.sv - data-memory side bus between processor and I/O port controller
interface io_port_controller_if;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] ReadData;
    logic        IOSelect;

    modport master (
        output Address,
        output WriteData,
        output MemWrite,
        output MemRead,
        input  ReadData,
        input  IOSelect
    );

    modport slave (
        input  Address,
        input  WriteData,
        input  MemWrite,
        input  MemRead,
        output ReadData,
        output IOSelect
    );
endinterface

// File: rtl/io_port_controller.sv
// rtl/io_port_controller.sv - memory-mapped output register, debounced input port and sticky change flag
module io_port_controller #(
    parameter logic [31:0] PORT_OUT_ADDR   = 32'h1001_0024,
    parameter logic [31:0] PORT_IN_ADDR    = 32'h1001_0028,
    parameter logic [31:0] STATUS_ADDR     = 32'h1001_002C,
    parameter int          DEBOUNCE_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    io_port_controller_if.slave    bus,
    input  logic [7:0]             PortIn,
    output logic [31:0]            PortOut,
    output logic                   InChanged
);

    // Terminal count: a mismatch seen on this many consecutive edges is accepted.
    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic [7:0] sync1;
    logic [7:0] sync2;
    logic [7:0] stable;
    logic [7:0] cnt;

    logic hit_out;
    logic hit_in;
    logic hit_status;
    logic accept;
    logic status_rd;

    // Exact full-width address decode; no aliasing anywhere in the I/O window.
    always_comb begin
        hit_out    = (bus.Address == PORT_OUT_ADDR);
        hit_in     = (bus.Address == PORT_IN_ADDR);
        hit_status = (bus.Address == STATUS_ADDR);
        status_rd  = bus.MemRead && hit_status;
        accept     = (sync2 != stable) && (cnt == CNT_LAST);
    end

    // Load path and write-back mux select, both settle within the lw cycle.
    always_comb begin
        bus.ReadData = 32'b0;
        bus.IOSelect = bus.MemRead && (hit_out || hit_in || hit_status);
        if (bus.MemRead) begin
            if (hit_out)
                bus.ReadData = PortOut;
            else if (hit_in)
                bus.ReadData = {24'b0, stable};
            else if (hit_status)
                bus.ReadData = {31'b0, InChanged};
        end
    end

    // Output register: only stores to PORT_OUT_ADDR land here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            PortOut <= 32'b0;
        else if (bus.MemWrite && hit_out)
            PortOut <= bus.WriteData;
    end

    // Two-flop synchronizer for the asynchronous switches.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 8'b0;
            sync2 <= 8'b0;
        end else begin
            sync1 <= PortIn;
            sync2 <= sync1;
        end
    end

    // Whole-vector debounce: any mismatch keeps counting, even if the value wanders.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stable <= 8'b0;
            cnt    <= 8'b0;
        end else if (sync2 == stable) begin
            cnt <= 8'b0;
        end else if (cnt == CNT_LAST) begin
            stable <= sync2;
            cnt    <= 8'b0;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end

    // Sticky change flag: a new accepted value beats a concurrent status read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            InChanged <= 1'b0;
        else if (accept)
            InChanged <= 1'b1;
        else if (status_rd)
            InChanged <= 1'b0;
    end

endmodule

// File: tb/tb_io_port_controller.sv
// tb/tb_io_port_controller.sv - directed self-checking bench for io_port_controller
module tb_io_port_controller;

    localparam logic [31:0] A_OUT    = 32'h1001_0024;
    localparam logic [31:0] A_IN     = 32'h1001_0028;
    localparam logic [31:0] A_STATUS = 32'h1001_002C;
    localparam logic [31:0] A_OTHER  = 32'h1001_0030;

    logic        clk;
    logic        reset;
    logic [7:0]  PortIn;
    logic [31:0] PortOut;
    logic        InChanged;

    int checks;
    int failures;

    io_port_controller_if bus ();

    io_port_controller dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.slave),
        .PortIn    (PortIn),
        .PortOut   (PortOut),
        .InChanged (InChanged)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_idle();
        bus.Address   = 32'h0;
        bus.WriteData = 32'h0;
        bus.MemWrite  = 1'b0;
        bus.MemRead   = 1'b0;
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data);
        bus.Address   = addr;
        bus.WriteData = data;
        bus.MemWrite  = 1'b1;
        bus.MemRead   = 1'b0;
        tick(1);
        bus_idle();
    endtask

    task automatic load_start(input logic [31:0] addr);
        bus.Address  = addr;
        bus.MemWrite = 1'b0;
        bus.MemRead  = 1'b1;
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        PortIn   = 8'h00;
        bus_idle();

        // Reset state
        #2;
        check("rst_portout", PortOut, 32'h0);
        check("rst_readdata", bus.ReadData, 32'h0);
        check("rst_iosel", {31'b0, bus.IOSelect}, 32'h0);
        check("rst_inchanged", {31'b0, InChanged}, 32'h0);
        tick(2);
        reset = 1'b0;
        tick(1);

        // Store then load back the output register
        store(A_OUT, 32'hDEAD_BEEF);
        check("sw_portout", PortOut, 32'hDEAD_BEEF);
        load_start(A_OUT);
        check("lw_out_data", bus.ReadData, 32'hDEAD_BEEF);
        check("lw_out_iosel", {31'b0, bus.IOSelect}, 32'h1);
        bus_idle();

        // Input acceptance after exactly 6 edges
        PortIn = 8'hA5;
        tick(5);
        check("deb_5_flag", {31'b0, InChanged}, 32'h0);
        load_start(A_IN);
        check("deb_5_in", bus.ReadData, 32'h0);
        bus_idle();
        tick(1);
        check("deb_6_flag", {31'b0, InChanged}, 32'h1);
        load_start(A_IN);
        check("deb_6_in", bus.ReadData, 32'h0000_00A5);
        check("deb_6_iosel", {31'b0, bus.IOSelect}, 32'h1);
        bus_idle();

        // Status read returns pre-clear value, then 0
        load_start(A_STATUS);
        check("stat_rd1", bus.ReadData, 32'h1);
        tick(1);
        check("stat_rd2", bus.ReadData, 32'h0);
        check("stat_flag_clr", {31'b0, InChanged}, 32'h0);
        bus_idle();

        // Three-cycle glitch is rejected and counter returns to 0
        PortIn = 8'h3C;
        tick(3);
        PortIn = 8'hA5;
        tick(5);
        check("glitch_cnt", {24'b0, dut.cnt}, 32'h0);
        check("glitch_flag", {31'b0, InChanged}, 32'h0);
        load_start(A_IN);
        check("glitch_in", bus.ReadData, 32'h0000_00A5);
        bus_idle();

        // Set wins over a status read on the same edge
        PortIn = 8'h5A;
        tick(6);
        check("sw2_flag", {31'b0, InChanged}, 32'h1);
        PortIn = 8'hC3;
        tick(5);
        load_start(A_STATUS);
        check("setwin_rd", bus.ReadData, 32'h1);
        tick(1);
        check("setwin_flag", {31'b0, InChanged}, 32'h1);
        check("setwin_rd2", bus.ReadData, 32'h1);
        tick(1);
        check("setwin_clr", {31'b0, InChanged}, 32'h0);
        load_start(A_IN);
        check("setwin_in", bus.ReadData, 32'h0000_00C3);
        bus_idle();

        // Unmapped load and ignored stores
        load_start(A_OTHER);
        check("unmap_data", bus.ReadData, 32'h0);
        check("unmap_iosel", {31'b0, bus.IOSelect}, 32'h0);
        bus_idle();
        PortIn = 8'h11;
        tick(6);
        check("ign_flag_pre", {31'b0, InChanged}, 32'h1);
        store(A_IN, 32'hFFFF_FFFF);
        store(A_STATUS, 32'h0);
        check("ign_portout", PortOut, 32'hDEAD_BEEF);
        check("ign_flag", {31'b0, InChanged}, 32'h1);
        load_start(A_IN);
        check("ign_in", bus.ReadData, 32'h0000_0011);
        bus_idle();

        // Reset mid-debounce and mid-store, then reacquire
        store(A_OUT, 32'h0000_1234);
        check("pre_rst_out", PortOut, 32'h0000_1234);
        PortIn = 8'hFF;
        tick(4);
        check("pre_rst_cnt", {24'b0, dut.cnt}, 32'h2);
        load_start(A_OUT);
        bus.MemWrite  = 1'b1;
        bus.WriteData = 32'h5555_5555;
        reset = 1'b1;
        #1;
        check("rst_async_out", PortOut, 32'h0);
        check("rst_async_flag", {31'b0, InChanged}, 32'h0);
        check("rst_async_rd", bus.ReadData, 32'h0);
        bus_idle();
        tick(2);
        reset = 1'b0;
        tick(5);
        check("reacq_5_flag", {31'b0, InChanged}, 32'h0);
        tick(1);
        check("reacq_6_flag", {31'b0, InChanged}, 32'h1);
        load_start(A_IN);
        check("reacq_in", bus.ReadData, 32'h0000_00FF);
        check("reacq_out", PortOut, 32'h0);
        bus_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
